// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its address checker.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFault
  } fetch_state_e;

  localparam logic [31:0] ROM_BASE   = 32'h0040_0000;
  localparam logic [31:0] RAM_BASE   = 32'h1001_0000;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational check of an address against the ROM window and word alignment.
// Written to be reused by a data-side address decoder as well.
module fetch_addr_check
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 32
) (
  input  logic [DATA_WIDTH-1:0] addr_i,
  output logic                  in_range_o,
  output logic                  misaligned_o
);

  localparam logic [DATA_WIDTH-1:0] RomBase  = DATA_WIDTH'(ROM_BASE);
  localparam logic [DATA_WIDTH:0]   RomBytes = (DATA_WIDTH+1)'(WORD_BYTES * MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] offset;

  // Offset is only meaningful once addr_i >= RomBase; the extra bit avoids overflow on the limit.
  assign offset       = addr_i - RomBase;
  assign in_range_o   = (addr_i >= RomBase) && ({1'b0, offset} < RomBytes);
  assign misaligned_o = (addr_i[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, registers the fetched
// instruction and hands it to decode over a valid/ready handshake.
// Optional feature: define FETCH_COUNTERS_EN to build saturating fetch/stall counters;
// otherwise fetch_count_o and stall_count_o are tied to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  input  logic [DATA_WIDTH-1:0] mem_instruction_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_addr_i,
  input  logic                  id_ready_i,
  output logic                  if_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fault_o,
  output logic [31:0]           fetch_count_o,
  output logic [31:0]           stall_count_o
);

  localparam logic [DATA_WIDTH-1:0] WordStep = DATA_WIDTH'(WORD_BYTES);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                  fault_q, fault_d;

  logic addr_in_range;
  logic addr_misaligned;
  logic fetch_ok;
  logic slot_free;

  fetch_addr_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_addr_check (
    .addr_i      (pc_q),
    .in_range_o  (addr_in_range),
    .misaligned_o(addr_misaligned)
  );

  assign fetch_ok      = addr_in_range && !addr_misaligned;
  assign slot_free     = !valid_q || id_ready_i;
  assign mem_address_o = pc_q;

  // Next-state: redirect beats everything; otherwise capture whenever the slot frees up.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q && !id_ready_i;  // a consume empties the slot unless refilled below
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    fault_d    = fault_q;

    if (redirect_i) begin
      pc_d    = redirect_addr_i;
      valid_d = 1'b0;
      state_d = StFetch;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StFetch;
        end
        StFetch: begin
          if (slot_free) begin
            if (fetch_ok) begin
              instr_d    = mem_instruction_i;
              pc_out_d   = pc_q;
              pc_plus4_d = pc_q + WordStep;
              valid_d    = 1'b1;
              pc_d       = pc_q + WordStep;
            end else begin
              state_d = StFault;
              fault_d = 1'b1;
            end
          end
        end
        StFault: begin
          fault_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_out_q   <= '0;
      pc_plus4_q <= WordStep;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      fault_q    <= fault_d;
    end
  end

  assign if_valid_o = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_out_q;
  assign pc_plus4_o = pc_plus4_q;
  assign fault_o    = fault_q;

`ifdef FETCH_COUNTERS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        consume;
  logic        stall;

  assign consume = valid_q && id_ready_i;
  assign stall   = valid_q && !id_ready_i;

  // Saturating counters; only reset clears them, redirect does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (consume && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;
`else
  assign fetch_count_o = '0;
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized traffic, every cycle compared
// against a transaction-level reference model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] TbRomBase = 32'h0040_0000;
  localparam logic [31:0] TbRomEnd  = 32'h0040_0080;

  logic        clk;
  logic        reset;
  logic [31:0] mem_address_o;
  logic [31:0] mem_instruction_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fault_o;
  logic [31:0] fetch_count_o;
  logic [31:0] stall_count_o;

  logic [31:0] rom [32];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pco, m_fcnt, m_scnt;
  bit          m_valid, m_fault, m_started;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .mem_address_o    (mem_address_o),
    .mem_instruction_i(mem_instruction_i),
    .redirect_i       (redirect_i),
    .redirect_addr_i  (redirect_addr_i),
    .id_ready_i       (id_ready_i),
    .if_valid_o       (if_valid_o),
    .instr_o          (instr_o),
    .pc_o             (pc_o),
    .pc_plus4_o       (pc_plus4_o),
    .fault_o          (fault_o),
    .fetch_count_o    (fetch_count_o),
    .stall_count_o    (stall_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational ROM; outside the window it returns an address-derived pattern.
  always_comb begin
    mem_instruction_i = mem_address_o ^ 32'hA5A5_5A5A;
    if (mem_address_o >= TbRomBase && mem_address_o < TbRomEnd)
      mem_instruction_i = rom[mem_address_o[6:2]];
  end

  function automatic bit is_legal(input logic [31:0] a);
    longint la;
    la = longint'({32'h0, a});
    return (a % 4 == 0) && (la >= longint'({32'h0, TbRomBase}))
           && (la < longint'({32'h0, TbRomBase}) + 4 * 32);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc      = TbRomBase;
    m_valid   = 0;
    m_fault   = 0;
    m_started = 0;
    m_instr   = '0;
    m_pco     = '0;
    m_fcnt    = '0;
    m_scnt    = '0;
  endtask

  // One clock of the fetch-stage rules, applied to the inputs currently driven.
  task automatic model_next();
    bit consume;
    consume = m_valid && id_ready_i;
`ifdef FETCH_COUNTERS_EN
    if (consume && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    if (m_valid && !id_ready_i && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
`endif
    if (redirect_i) begin
      m_pc      = redirect_addr_i;
      m_valid   = 0;
      m_fault   = 0;
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
      if (consume) m_valid = 0;
    end else if (m_fault || (m_valid && !id_ready_i)) begin
      if (consume) m_valid = 0;
    end else if (is_legal(m_pc)) begin
      m_instr = rom[(m_pc - TbRomBase) / 4];
      m_pco   = m_pc;
      m_valid = 1;
      m_pc    = m_pc + 4;
    end else begin
      m_fault = 1;
      m_valid = 0;
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".addr"},   mem_address_o, m_pc);
    check({ph, ".valid"},  {31'b0, if_valid_o}, {31'b0, m_valid});
    check({ph, ".fault"},  {31'b0, fault_o}, {31'b0, m_fault});
    check({ph, ".instr"},  instr_o, m_instr);
    check({ph, ".pc_o"},   pc_o, m_pco);
    check({ph, ".pc4"},    pc_plus4_o, m_pco + 32'd4);
    check({ph, ".fcnt"},   fetch_count_o, m_fcnt);
    check({ph, ".scnt"},   stall_count_o, m_scnt);
  endtask

  task automatic step(input string ph, input logic rd, input logic [31:0] tgt, input logic rdy);
    redirect_i      = rd;
    redirect_addr_i = tgt;
    id_ready_i      = rdy;
    model_next();
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    redirect_i = 1'b0;
    id_ready_i = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      model_reset();
      compare_all("reset");
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    reset           = 1'b1;
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
    id_ready_i      = 1'b1;
    model_reset();

    // Reset and stream.
    do_reset(2);
    check("rst_pc4", pc_plus4_o, 32'd4);
    for (int i = 0; i < 9; i++) step("stream", 0, '0, 1);
    check("stream_pc_last", pc_o, 32'h0040_001C);
    step("stream", 0, '0, 1);
`ifdef FETCH_COUNTERS_EN
    check("stream_fcnt8", fetch_count_o, 32'd8);
`else
    check("stream_fcnt_off", fetch_count_o, 32'd0);
`endif

    // Stall for three cycles at 0x400008, then resume.
    do_reset(2);
    for (int i = 0; i < 4; i++) step("pre_stall", 0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, '0, 0);
      check("stall_pc_o", pc_o, 32'h0040_0008);
      check("stall_addr", mem_address_o, 32'h0040_000C);
    end
`ifdef FETCH_COUNTERS_EN
    check("stall_scnt3", stall_count_o, 32'd3);
`endif
    step("resume", 0, '0, 1);
    check("resume_pc_o", pc_o, 32'h0040_000C);

    // Redirect while stalled flushes the held instruction.
    do_reset(2);
    for (int i = 0; i < 4; i++) step("pre_rd", 0, '0, 1);
    step("rd_stall", 0, '0, 0);
    step("rd_stall", 1, 32'h0040_0014, 0);
    check("rd_flush_valid", {31'b0, if_valid_o}, 32'd0);
    step("rd_after", 0, '0, 1);
    check("rd_target_pc_o", pc_o, 32'h0040_0014);

    // End of ROM faults, redirect recovers.
    step("eor", 1, 32'h0040_0070, 1);
    for (int i = 0; i < 4; i++) step("eor", 0, '0, 1);
    check("eor_last_pc_o", pc_o, 32'h0040_007C);
    check("eor_addr", mem_address_o, 32'h0040_0080);
    step("eor_fault", 0, '0, 1);
    check("eor_fault_hi", {31'b0, fault_o}, 32'd1);
    for (int i = 0; i < 2; i++) step("eor_hold", 0, '0, 1);
    step("eor_rd", 1, 32'h0040_0000, 1);
    check("eor_fault_clr", {31'b0, fault_o}, 32'd0);
    step("eor_restart", 0, '0, 1);
    check("eor_restart_pc", pc_o, 32'h0040_0000);

    // Misaligned, RAM and rollover targets.
    step("mis", 1, 32'h0040_0002, 1);
    step("mis", 0, '0, 1);
    check("mis_fault", {31'b0, fault_o}, 32'd1);
    step("ram", 1, 32'h1001_0000, 1);
    step("ram", 0, '0, 1);
    check("ram_fault", {31'b0, fault_o}, 32'd1);
    step("roll", 1, 32'hFFFF_FFFC, 0);
    step("roll", 0, '0, 0);

    // Reset while faulted.
    do_reset(1);
    check("rst_fault_pc_o", pc_o, 32'd0);
    step("rst_restart", 0, '0, 1);
    step("rst_restart", 0, '0, 1);
    check("rst_restart_pc", pc_o, 32'h0040_0000);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        case ($urandom_range(0, 5))
          0, 1, 2: tgt = TbRomBase + (32'($urandom_range(0, 31)) << 2);
          3:       tgt = 32'h0040_0070 + (32'($urandom_range(0, 3)) << 2);
          4:       tgt = TbRomBase + 32'($urandom_range(0, 127));
          default: tgt = $urandom;
        endcase
        step("rand", ($urandom_range(0, 15) == 0), tgt, ($urandom_range(0, 3) != 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
